// File: rtl/common_cfg.sv
// Shared configuration for the timestamp-ordered frame reader.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package common_cfg;

    localparam int TS_WIDTH       = 56;
    localparam int DATA_WIDTH     = 128;
    localparam int FRAME_WORDS    = 4;
    localparam int BEAT_WIDTH     = $clog2(FRAME_WORDS);
    localparam int TSQ_ADDR_WIDTH = 4;
    localparam int TSQ_DEPTH      = 1 << TSQ_ADDR_WIDTH;

    typedef enum logic {
        ARB_IDLE_ST,
        ARB_RD_ST
    } arb_state_t;

    // Per-cycle read tag travelling alongside the channel FIFO read latency.
    typedef struct packed {
        logic rd;
        logic sop;
        logic eop;
        logic chnl;
    } rd_tag_t;

endpackage

// File: rtl/ts_queue.sv
// Timestamp FIFO with show-ahead head; entry visible one cycle after push.
// Latency: push -> not-empty 1 cycle; pop takes effect at the clock edge.
// Backpressure: none; a push while full is dropped and flagged on ovf (1-cycle pulse).
// Ports: push/pushTs write side, pop read side, headTs/empty/usedw status, ovf pulse.
module ts_queue
    import common_cfg::*;
(
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      push,
    input  logic [TS_WIDTH-1:0]       pushTs,
    input  logic                      pop,
    output logic [TS_WIDTH-1:0]       headTs,
    output logic                      empty,
    output logic [TSQ_ADDR_WIDTH:0]   usedw,
    output logic                      ovf
);

    logic [TS_WIDTH-1:0]       mem [TSQ_DEPTH];
    logic [TSQ_ADDR_WIDTH-1:0] wrPtr;
    logic [TSQ_ADDR_WIDTH-1:0] rdPtr;
    logic                      full;
    logic                      wrEn;
    logic                      rdEn;

    assign full   = (usedw == (TSQ_ADDR_WIDTH+1)'(TSQ_DEPTH));
    assign empty  = (usedw == '0);
    // Full is judged on the pre-edge occupancy, so a same-cycle pop does not rescue the push.
    assign wrEn   = push & ~full;
    assign rdEn   = pop & ~empty;
    assign headTs = mem[rdPtr];

    always_ff @(posedge clk) begin
        if (wrEn) begin
            mem[wrPtr] <= pushTs;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrPtr <= '0;
            rdPtr <= '0;
            usedw <= '0;
            ovf   <= 1'b0;
        end else begin
            ovf <= push & full;
            if (wrEn) begin
                wrPtr <= wrPtr + 1'b1;
            end
            if (rdEn) begin
                rdPtr <= rdPtr + 1'b1;
            end
            case ({wrEn, rdEn})
                2'b10:   usedw <= usedw + 1'b1;
                2'b01:   usedw <= usedw - 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/dat_ts_arbiter_reader.sv
// Picks the oldest-timestamp frame across two channel FIFOs and bursts it downstream.
// Latency: queue push -> DAL_READ 2 cycles; DAL_READ -> oARB_VALID RD_LAT+1 cycles.
// Backpressure: iDN_AFULL only blocks new bursts in IDLE; a started burst always completes.
// Ports: iCHn_GTS_VALID/iCHn_GOOD_TS timestamp push, iCHn_DAL_DATA/oCHn_DAL_READ channel FIFO,
//        oARB_* framed output stream, oTSQ_OVF/oTSQ_WORDS0/1 queue status.
module dat_ts_arbiter_reader
    import common_cfg::*;
#(
    parameter int RD_LAT = 1
)(
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      iCH0_GTS_VALID,
    input  logic [TS_WIDTH-1:0]       iCH0_GOOD_TS,
    input  logic [DATA_WIDTH-1:0]     iCH0_DAL_DATA,
    output logic                      oCH0_DAL_READ,
    input  logic                      iCH1_GTS_VALID,
    input  logic [TS_WIDTH-1:0]       iCH1_GOOD_TS,
    input  logic [DATA_WIDTH-1:0]     iCH1_DAL_DATA,
    output logic                      oCH1_DAL_READ,
    input  logic                      iDN_AFULL,
    output logic [DATA_WIDTH-1:0]     oARB_DATA,
    output logic                      oARB_VALID,
    output logic                      oARB_SOP,
    output logic                      oARB_EOP,
    output logic                      oARB_CHNL,
    output logic [1:0]                oTSQ_OVF,
    output logic [TSQ_ADDR_WIDTH:0]   oTSQ_WORDS0,
    output logic [TSQ_ADDR_WIDTH:0]   oTSQ_WORDS1
);

    arb_state_t             state;
    arb_state_t             stateNxt;
    logic [BEAT_WIDTH-1:0]  beat;
    logic [BEAT_WIDTH-1:0]  beatNxt;
    // Channel of the current/most recent burst; doubles as the tie-break pointer.
    logic                   grantCh;
    logic                   grantNxt;
    logic                   pickCh;
    logic [TS_WIDTH-1:0]    head0;
    logic [TS_WIDTH-1:0]    head1;
    logic                   empty0;
    logic                   empty1;
    logic                   ovf0;
    logic                   ovf1;
    logic                   rdActive;
    logic                   firstBeat;
    logic                   lastBeat;
    rd_tag_t                tagNow;
    rd_tag_t                tagDly [RD_LAT];
    rd_tag_t                tap;

    assign rdActive      = (state == ARB_RD_ST);
    assign firstBeat     = (beat == '0);
    assign lastBeat      = (beat == BEAT_WIDTH'(FRAME_WORDS - 1));
    assign oCH0_DAL_READ = rdActive & ~grantCh;
    assign oCH1_DAL_READ = rdActive &  grantCh;
    assign oTSQ_OVF      = {ovf1, ovf0};

    ts_queue u_tsq0 (
        .clk    (clk),
        .rst_n  (rst_n),
        .push   (iCH0_GTS_VALID),
        .pushTs (iCH0_GOOD_TS),
        .pop    (oCH0_DAL_READ & firstBeat),
        .headTs (head0),
        .empty  (empty0),
        .usedw  (oTSQ_WORDS0),
        .ovf    (ovf0)
    );

    ts_queue u_tsq1 (
        .clk    (clk),
        .rst_n  (rst_n),
        .push   (iCH1_GTS_VALID),
        .pushTs (iCH1_GOOD_TS),
        .pop    (oCH1_DAL_READ & firstBeat),
        .headTs (head1),
        .empty  (empty1),
        .usedw  (oTSQ_WORDS1),
        .ovf    (ovf1)
    );

    // Oldest timestamp wins; equal timestamps go to the channel not served last.
    always_comb begin
        pickCh = ~grantCh;
        if (empty1) begin
            pickCh = 1'b0;
        end else if (empty0) begin
            pickCh = 1'b1;
        end else if (head0 < head1) begin
            pickCh = 1'b0;
        end else if (head1 < head0) begin
            pickCh = 1'b1;
        end
    end

    always_comb begin
        stateNxt = state;
        beatNxt  = beat;
        grantNxt = grantCh;
        case (state)
            ARB_IDLE_ST: begin
                if (!iDN_AFULL && (!empty0 || !empty1)) begin
                    stateNxt = ARB_RD_ST;
                    beatNxt  = '0;
                    grantNxt = pickCh;
                end
            end
            ARB_RD_ST: begin
                if (lastBeat) begin
                    stateNxt = ARB_IDLE_ST;
                end else begin
                    beatNxt = beat + 1'b1;
                end
            end
            default: stateNxt = ARB_IDLE_ST;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ARB_IDLE_ST;
            beat    <= '0;
            grantCh <= 1'b1;
        end else begin
            state   <= stateNxt;
            beat    <= beatNxt;
            grantCh <= grantNxt;
        end
    end

    // Tags wait out the channel FIFO read latency so they line up with iCHn_DAL_DATA.
    assign tagNow = {rdActive, rdActive & firstBeat, rdActive & lastBeat, rdActive & grantCh};
    assign tap    = tagDly[RD_LAT-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < RD_LAT; i++) begin
                tagDly[i] <= '0;
            end
        end else begin
            tagDly[0] <= tagNow;
            for (int i = 1; i < RD_LAT; i++) begin
                tagDly[i] <= tagDly[i-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            oARB_DATA  <= '0;
            oARB_VALID <= 1'b0;
            oARB_SOP   <= 1'b0;
            oARB_EOP   <= 1'b0;
            oARB_CHNL  <= 1'b0;
        end else begin
            oARB_VALID <= tap.rd;
            oARB_SOP   <= tap.sop;
            oARB_EOP   <= tap.eop;
            oARB_CHNL  <= tap.chnl;
            oARB_DATA  <= tap.rd ? (tap.chnl ? iCH1_DAL_DATA : iCH0_DAL_DATA) : '0;
        end
    end

endmodule

// File: tb/tb_dat_ts_arbiter_reader.sv
// Bench for dat_ts_arbiter_reader: transaction-level model plus directed scenarios.
// Latency: n/a.
// Backpressure: driven via iDN_AFULL in the scenarios.
module tb_dat_ts_arbiter_reader;
    import common_cfg::*;

    localparam int RD_LAT = 1;

    logic                    clk = 1'b0;
    logic                    rst_n = 1'b0;
    logic                    iCH0_GTS_VALID = 1'b0;
    logic [TS_WIDTH-1:0]     iCH0_GOOD_TS = '0;
    logic [DATA_WIDTH-1:0]   iCH0_DAL_DATA = '0;
    logic                    oCH0_DAL_READ;
    logic                    iCH1_GTS_VALID = 1'b0;
    logic [TS_WIDTH-1:0]     iCH1_GOOD_TS = '0;
    logic [DATA_WIDTH-1:0]   iCH1_DAL_DATA = '0;
    logic                    oCH1_DAL_READ;
    logic                    iDN_AFULL = 1'b0;
    logic [DATA_WIDTH-1:0]   oARB_DATA;
    logic                    oARB_VALID;
    logic                    oARB_SOP;
    logic                    oARB_EOP;
    logic                    oARB_CHNL;
    logic [1:0]              oTSQ_OVF;
    logic [TSQ_ADDR_WIDTH:0] oTSQ_WORDS0;
    logic [TSQ_ADDR_WIDTH:0] oTSQ_WORDS1;

    dat_ts_arbiter_reader #(.RD_LAT(RD_LAT)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .iCH0_GTS_VALID (iCH0_GTS_VALID),
        .iCH0_GOOD_TS   (iCH0_GOOD_TS),
        .iCH0_DAL_DATA  (iCH0_DAL_DATA),
        .oCH0_DAL_READ  (oCH0_DAL_READ),
        .iCH1_GTS_VALID (iCH1_GTS_VALID),
        .iCH1_GOOD_TS   (iCH1_GOOD_TS),
        .iCH1_DAL_DATA  (iCH1_DAL_DATA),
        .oCH1_DAL_READ  (oCH1_DAL_READ),
        .iDN_AFULL      (iDN_AFULL),
        .oARB_DATA      (oARB_DATA),
        .oARB_VALID     (oARB_VALID),
        .oARB_SOP       (oARB_SOP),
        .oARB_EOP       (oARB_EOP),
        .oARB_CHNL      (oARB_CHNL),
        .oTSQ_OVF       (oTSQ_OVF),
        .oTSQ_WORDS0    (oTSQ_WORDS0),
        .oTSQ_WORDS1    (oTSQ_WORDS1)
    );

    initial forever #5 clk = ~clk;

    int nVec  = 0;
    int nFail = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        nVec++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s @%0t: got %h want %h", nm, $time, act, exp);
        end
    endtask

    // Frame word: tag, channel, per-channel frame sequence number, beat index.
    function automatic logic [127:0] mkWord(input int ch, input int seq, input int beat);
        return {8'hA5, 7'd0, ch[0], 56'(seq), 56'(beat)};
    endfunction

    // ---------------- channel FIFO stand-ins (q valid one cycle after rdreq) ----------------
    logic [127:0] chFifo0[$];
    logic [127:0] chFifo1[$];
    int           tbSeq0 = 0;
    int           tbSeq1 = 0;

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            chFifo0.delete();
            chFifo1.delete();
            iCH0_DAL_DATA <= '0;
            iCH1_DAL_DATA <= '0;
        end else begin
            if (oCH0_DAL_READ && chFifo0.size() > 0) iCH0_DAL_DATA <= chFifo0.pop_front();
            if (oCH1_DAL_READ && chFifo1.size() > 0) iCH1_DAL_DATA <= chFifo1.pop_front();
        end
    end

    // ---------------- behavioural model ----------------
    typedef struct packed {
        logic         vld;
        logic         sop;
        logic         eop;
        logic         chnl;
        logic [127:0] dat;
    } exp_t;

    logic [55:0] mQ0[$];
    logic [55:0] mQ1[$];
    int          mBeat = -1;   // -1: no burst this cycle, else beat index
    int          mCh   = 1;    // channel of the current / last burst
    int          mCur  = 0;    // frame sequence number of the current burst
    int          mSeq0 = 0;
    int          mSeq1 = 0;
    logic [1:0]  mOvf  = '0;
    exp_t        pipe [RD_LAT+1] = '{default: '0};
    exp_t        mE;
    bit          mF0, mF1;
    int          mPick;

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            mQ0.delete();
            mQ1.delete();
            mBeat = -1;
            mCh   = 1;
            mCur  = 0;
            mSeq0 = 0;
            mSeq1 = 0;
            mOvf  = '0;
            for (int i = 0; i <= RD_LAT; i++) pipe[i] = '0;
        end else begin
            // the word read this cycle appears on the output RD_LAT+1 cycles later
            for (int i = RD_LAT; i > 0; i--) pipe[i] = pipe[i-1];
            mE = '0;
            if (mBeat >= 0) begin
                mE.vld  = 1'b1;
                mE.sop  = (mBeat == 0);
                mE.eop  = (mBeat == FRAME_WORDS - 1);
                mE.chnl = mCh[0];
                mE.dat  = mkWord(mCh, mCur, mBeat);
            end
            pipe[0] = mE;
            mF0 = (mQ0.size() >= TSQ_DEPTH);
            mF1 = (mQ1.size() >= TSQ_DEPTH);
            if (mBeat < 0) begin
                if (!iDN_AFULL && (mQ0.size() > 0 || mQ1.size() > 0)) begin
                    if (mQ1.size() == 0)       mPick = 0;
                    else if (mQ0.size() == 0)  mPick = 1;
                    else if (mQ0[0] < mQ1[0])  mPick = 0;
                    else if (mQ1[0] < mQ0[0])  mPick = 1;
                    else                       mPick = 1 - mCh;
                    mCh = mPick;
                    if (mPick == 0) begin mCur = mSeq0; mSeq0++; end
                    else            begin mCur = mSeq1; mSeq1++; end
                    mBeat = 0;
                end
            end else begin
                if (mBeat == 0) begin
                    if (mCh == 0) void'(mQ0.pop_front());
                    else          void'(mQ1.pop_front());
                end
                mBeat = (mBeat == FRAME_WORDS - 1) ? -1 : mBeat + 1;
            end
            mOvf = {iCH1_GTS_VALID & mF1, iCH0_GTS_VALID & mF0};
            if (iCH0_GTS_VALID && !mF0) mQ0.push_back(iCH0_GOOD_TS);
            if (iCH1_GTS_VALID && !mF1) mQ1.push_back(iCH1_GOOD_TS);
        end
    end

    // ---------------- per-cycle compare + monitor ----------------
    int   cyc = 0;
    logic seenCh[$];
    int   rises[$];
    int   eopCnt  = 0;
    int   ovfCnt1 = 0;
    logic prevRd  = 1'b0;

    initial forever begin
        @(negedge clk);
        cyc++;
        chk("cyc_rd0",   128'(oCH0_DAL_READ), 128'(mBeat >= 0 && mCh == 0));
        chk("cyc_rd1",   128'(oCH1_DAL_READ), 128'(mBeat >= 0 && mCh == 1));
        chk("cyc_vld",   128'(oARB_VALID),    128'(pipe[RD_LAT].vld));
        chk("cyc_sop",   128'(oARB_SOP),      128'(pipe[RD_LAT].sop));
        chk("cyc_eop",   128'(oARB_EOP),      128'(pipe[RD_LAT].eop));
        chk("cyc_chnl",  128'(oARB_CHNL),     128'(pipe[RD_LAT].chnl));
        if (pipe[RD_LAT].vld) chk("cyc_data", oARB_DATA, pipe[RD_LAT].dat);
        chk("cyc_ovf",   128'(oTSQ_OVF),      128'(mOvf));
        chk("cyc_words0", 128'(oTSQ_WORDS0),  128'(mQ0.size()));
        chk("cyc_words1", 128'(oTSQ_WORDS1),  128'(mQ1.size()));
        if (oARB_VALID && oARB_SOP) seenCh.push_back(oARB_CHNL);
        if (oARB_VALID && oARB_EOP) eopCnt++;
        if (oTSQ_OVF[1]) ovfCnt1++;
        if ((oCH0_DAL_READ || oCH1_DAL_READ) && !prevRd) rises.push_back(cyc);
        prevRd = oCH0_DAL_READ | oCH1_DAL_READ;
    end

    // ---------------- stimulus helpers ----------------
    task automatic clearRecords();
        tbSeq0  = 0;
        tbSeq1  = 0;
        eopCnt  = 0;
        ovfCnt1 = 0;
        seenCh.delete();
        rises.delete();
    endtask

    task automatic doReset();
        @(negedge clk);
        #2 rst_n = 1'b0;
        iCH0_GTS_VALID = 1'b0;
        iCH1_GTS_VALID = 1'b0;
        iDN_AFULL      = 1'b0;
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        clearRecords();
        @(negedge clk);
    endtask

    // Frame data lands in the channel FIFO one cycle ahead of its timestamp.
    task automatic push(input bit v0, input logic [55:0] t0, input bit v1, input logic [55:0] t1,
                        input bit withData);
        if (withData) begin
            if (v0) begin
                for (int b = 0; b < FRAME_WORDS; b++) chFifo0.push_back(mkWord(0, tbSeq0, b));
                tbSeq0++;
            end
            if (v1) begin
                for (int b = 0; b < FRAME_WORDS; b++) chFifo1.push_back(mkWord(1, tbSeq1, b));
                tbSeq1++;
            end
        end
        @(negedge clk);
        iCH0_GTS_VALID = v0;
        iCH0_GOOD_TS   = v0 ? t0 : '0;
        iCH1_GTS_VALID = v1;
        iCH1_GOOD_TS   = v1 ? t1 : '0;
        @(negedge clk);
        iCH0_GTS_VALID = 1'b0;
        iCH1_GTS_VALID = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // reset state
        repeat (2) @(negedge clk);
        #1;
        chk("rst_valid", 128'(oARB_VALID), 128'(0));
        chk("rst_rd",    128'({oCH1_DAL_READ, oCH0_DAL_READ}), 128'(0));
        chk("rst_words", 128'({oTSQ_WORDS1, oTSQ_WORDS0}), 128'(0));
        doReset();

        // 1: single ch0 frame, exact cycle placement
        push(1'b1, 56'h100, 1'b0, 56'h0, 1'b1);
        for (int k = 2; k <= 9; k++) begin
            #1;
            chk($sformatf("t1_rd_n%0d", k),  128'(oCH0_DAL_READ), 128'(k >= 3 && k <= 6));
            chk($sformatf("t1_vld_n%0d", k), 128'(oARB_VALID),    128'(k >= 5 && k <= 8));
            if (k == 5) begin
                chk("t1_sop",  128'(oARB_SOP),  128'(1));
                chk("t1_chnl", 128'(oARB_CHNL), 128'(0));
                chk("t1_d0",   oARB_DATA, 128'hA500_0000_0000_0000_0000_0000_0000_0000);
            end
            if (k == 8) begin
                chk("t1_eop", 128'(oARB_EOP), 128'(1));
                chk("t1_d3",  oARB_DATA, 128'hA500_0000_0000_0000_0000_0000_0000_0003);
            end
            @(negedge clk);
        end

        // 2: oldest timestamp first, one idle cycle between bursts
        doReset();
        push(1'b1, 56'h500, 1'b1, 56'h200, 1'b1);
        repeat (14) @(negedge clk);
        #1;
        chk("t2_frames", 128'(seenCh.size()), 128'(2));
        chk("t2_first",  128'(seenCh[0]), 128'(1));
        chk("t2_second", 128'(seenCh[1]), 128'(0));
        chk("t2_gap",    128'(rises[1] - rises[0]), 128'(FRAME_WORDS + 1));

        // 3: equal timestamps alternate, starting with ch0
        doReset();
        for (int i = 0; i < 3; i++) push(1'b1, 56'h300, 1'b1, 56'h300, 1'b1);
        repeat (40) @(negedge clk);
        #1;
        chk("t3_frames", 128'(seenCh.size()), 128'(6));
        for (int i = 0; i < 6; i++) chk($sformatf("t3_order%0d", i), 128'(seenCh[i]), 128'(i % 2));

        // 4: almost-full during beat 1
        doReset();
        push(1'b1, 56'h10, 1'b1, 56'h20, 1'b1);
        repeat (2) @(negedge clk);
        iDN_AFULL = 1'b1;
        repeat (8) @(negedge clk);
        iDN_AFULL = 1'b0;
        #1;
        chk("t4_one_burst", 128'(rises.size()), 128'(1));
        chk("t4_eop_done",  128'(eopCnt), 128'(1));
        chk("t4_idle_rd",   128'({oCH1_DAL_READ, oCH0_DAL_READ}), 128'(0));
        @(negedge clk);
        #1;
        chk("t4_restart",   128'(oCH1_DAL_READ), 128'(1));
        repeat (8) @(negedge clk);
        #1;
        chk("t4_frames",    128'(seenCh.size()), 128'(2));
        chk("t4_order",     128'({seenCh[0], seenCh[1]}), 128'(2'b01));

        // 5: ch1 queue overflow, then drain in push order
        doReset();
        iDN_AFULL = 1'b1;
        for (int i = 0; i < 17; i++) push(1'b0, 56'h0, 1'b1, 56'(100 + i), i < 16);
        repeat (2) @(negedge clk);
        #1;
        chk("t5_words1", 128'(oTSQ_WORDS1), 128'(16));
        chk("t5_ovf",    128'(ovfCnt1), 128'(1));
        iDN_AFULL = 1'b0;
        repeat (90) @(negedge clk);
        #1;
        chk("t5_frames", 128'(seenCh.size()), 128'(16));
        chk("t5_empty",  128'(oTSQ_WORDS1), 128'(0));
        chk("t5_all_ch1", 128'(seenCh.sum() with (int'(item))), 128'(16));

        // 6: reset during beat 2
        doReset();
        push(1'b1, 56'h40, 1'b0, 56'h0, 1'b1);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_rd",    128'({oCH1_DAL_READ, oCH0_DAL_READ}), 128'(0));
        chk("t6_vld",   128'({oARB_VALID, oARB_SOP, oARB_EOP, oARB_CHNL}), 128'(0));
        chk("t6_data",  oARB_DATA, 128'(0));
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        tbSeq0 = 0;
        tbSeq1 = 0;
        repeat (8) @(negedge clk);
        #1;
        chk("t6_no_eop", 128'(eopCnt), 128'(0));
        chk("t6_words",  128'({oTSQ_WORDS1, oTSQ_WORDS0}), 128'(0));
        push(1'b1, 56'h41, 1'b0, 56'h0, 1'b1);
        repeat (10) @(negedge clk);
        #1;
        chk("t6_recover", 128'(eopCnt), 128'(1));

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nFail);
        $finish;
    end

endmodule
